// File: rtl/spi_frame_receiver.sv
// Serial configuration frame receiver: MSB-first address while REGSEL=1, LSB-first
// data while REGSEL=0, committed into a small slave register bank.
module spi_frame_receiver #(
   parameter int ADDR_W     = 5,
   parameter int DATA_W     = 30,
   parameter int NUM_SLAVES = 23
) (
   input  logic              clk_REGSEL,
   input  logic              RST,
   input  logic              GRST,
   input  logic              SIN,
   input  logic              REGSEL,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              wr_stb,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              frame_err,
   output logic              addr_err,
   output logic              busy
);

   localparam int ACNT_W = $clog2(ADDR_W + 1);
   localparam int DCNT_W = $clog2(DATA_W);
   localparam logic [ACNT_W-1:0] ACNT_FULL = ACNT_W'(ADDR_W);
   localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DATA_W - 1);
   localparam logic [ADDR_W-1:0] SLAVES_A  = ADDR_W'(NUM_SLAVES);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, WAIT} state_t;

   state_t             state;
   logic [ADDR_W-1:0]  addr_sr;
   logic [DATA_W-1:0]  data_sr;
   logic [ACNT_W-1:0]  acnt;
   logic [DCNT_W-1:0]  dcnt;
   logic [DATA_W-1:0]  bank [NUM_SLAVES];

   always_ff @(posedge clk_REGSEL or negedge RST) begin
      if (!RST) begin
         state     <= IDLE;
         addr_sr   <= '0;
         data_sr   <= '0;
         acnt      <= '0;
         dcnt      <= '0;
         wr_stb    <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         frame_err <= 1'b0;
         addr_err  <= 1'b0;
         for (int unsigned i = 0; i < NUM_SLAVES; i++) bank[i] <= '0;
      end else if (GRST) begin
         state     <= IDLE;
         addr_sr   <= '0;
         data_sr   <= '0;
         acnt      <= '0;
         dcnt      <= '0;
         wr_stb    <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         frame_err <= 1'b0;
         addr_err  <= 1'b0;
         for (int unsigned i = 0; i < NUM_SLAVES; i++) bank[i] <= '0;
      end else begin
         wr_stb    <= 1'b0;
         frame_err <= 1'b0;
         addr_err  <= 1'b0;
         case (state)
            IDLE, WAIT: begin
               if (REGSEL) begin
                  addr_sr <= {{(ADDR_W-1){1'b0}}, SIN};
                  acnt    <= ACNT_W'(1);
                  state   <= ADDR;
               end
            end
            ADDR: begin
               if (REGSEL) begin
                  addr_sr <= {addr_sr[ADDR_W-2:0], SIN};
                  if (acnt != ACNT_FULL) acnt <= acnt + 1'b1;
               end else if (acnt < ACNT_FULL) begin
                  frame_err <= 1'b1;
                  acnt      <= '0;
                  state     <= WAIT;
               end else begin
                  data_sr <= {{(DATA_W-1){1'b0}}, SIN};
                  dcnt    <= DCNT_W'(1);
                  state   <= DATA;
               end
            end
            DATA: begin
               if (REGSEL) begin
                  // Early rise aborts the frame and the same edge opens a new one.
                  frame_err <= 1'b1;
                  addr_sr   <= {{(ADDR_W-1){1'b0}}, SIN};
                  acnt      <= ACNT_W'(1);
                  dcnt      <= '0;
                  state     <= ADDR;
               end else if (dcnt == DCNT_LAST) begin
                  if (addr_sr < SLAVES_A) begin
                     bank[addr_sr] <= {SIN, data_sr[DATA_W-2:0]};
                     wr_stb        <= 1'b1;
                     wr_addr       <= addr_sr;
                     wr_data       <= {SIN, data_sr[DATA_W-2:0]};
                  end else begin
                     addr_err <= 1'b1;
                  end
                  acnt  <= '0;
                  dcnt  <= '0;
                  state <= WAIT;
               end else begin
                  data_sr[dcnt] <= SIN;
                  dcnt          <= dcnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state == ADDR) || (state == DATA);

   always_comb begin
      rd_data = '0;
      if (rd_addr < SLAVES_A) rd_data = bank[rd_addr];
   end

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Scoreboard bench for spi_frame_receiver: expected strobes/errors queued as frames
// are driven, popped as the receiver reports them; bank checked against a model.
module tb_spi_frame_receiver;

   logic        clk_REGSEL = 1'b0;
   logic        RST = 1'b0;
   logic        GRST = 1'b0;
   logic        SIN = 1'b0;
   logic        REGSEL = 1'b0;
   logic [4:0]  rd_addr = '0;
   logic [29:0] rd_data;
   logic        wr_stb;
   logic [4:0]  wr_addr;
   logic [29:0] wr_data;
   logic        frame_err;
   logic        addr_err;
   logic        busy;

   spi_frame_receiver #(.ADDR_W(5), .DATA_W(30), .NUM_SLAVES(23)) dut (
      .clk_REGSEL(clk_REGSEL), .RST(RST), .GRST(GRST), .SIN(SIN), .REGSEL(REGSEL),
      .rd_addr(rd_addr), .rd_data(rd_data), .wr_stb(wr_stb), .wr_addr(wr_addr),
      .wr_data(wr_data), .frame_err(frame_err), .addr_err(addr_err), .busy(busy)
   );

   always #5 clk_REGSEL = ~clk_REGSEL;

   // kind: {frame_err, addr_err, wr_stb}
   typedef struct packed {
      logic [2:0]  kind;
      logic [4:0]  a;
      logic [29:0] d;
   } exp_t;

   exp_t        sb[$];
   logic [29:0] mdl [23];
   logic [4:0]  last_a;
   logic [29:0] last_d;
   int          n_tests = 0;
   int          n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   always @(negedge clk_REGSEL) begin
      if (wr_stb || addr_err || frame_err) begin
         if (sb.size() == 0) begin
            check("unexpected_event", {29'd0, frame_err, addr_err, wr_stb}, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("event_kind", {29'd0, frame_err, addr_err, wr_stb}, {29'd0, e.kind});
            if (e.kind == 3'b001) begin
               check("wr_addr", {27'd0, wr_addr}, {27'd0, e.a});
               check("wr_data", {2'd0, wr_data}, {2'd0, e.d});
            end
         end
      end
   end

   task automatic drive(input logic rs, input logic s);
      @(negedge clk_REGSEL);
      REGSEL = rs;
      SIN    = s;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
   endtask

   task automatic clear_model();
      for (int i = 0; i < 23; i++) mdl[i] = '0;
      last_a = '0;
      last_d = '0;
   endtask

   task automatic send_frame(input logic [4:0] a, input logic [29:0] d);
      for (int i = 4; i >= 0; i--) drive(1'b1, a[i]);
      for (int j = 0; j < 30; j++) drive(1'b0, d[j]);
      if (a < 5'd23) begin
         sb.push_back('{kind: 3'b001, a: a, d: d});
         mdl[a] = d;
         last_a = a;
         last_d = d;
      end else begin
         sb.push_back('{kind: 3'b010, a: a, d: d});
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_wr_addr"}, {27'd0, wr_addr}, {27'd0, last_a});
      check({tag, "_wr_data"}, {2'd0, wr_data}, {2'd0, last_d});
      check({tag, "_pending"}, sb.size(), 32'd0);
      for (int i = 0; i < 32; i++) begin
         rd_addr = 5'(i);
         #1;
         check({tag, "_rd"}, {2'd0, rd_data}, (i < 23) ? {2'd0, mdl[i]} : 32'd0);
      end
   endtask

   initial begin
      clear_model();
      #12;
      check("rst_wr_stb", {31'd0, wr_stb}, 32'd0);
      check("rst_frame_err", {31'd0, frame_err}, 32'd0);
      check("rst_addr_err", {31'd0, addr_err}, 32'd0);
      check_state("reset");
      @(negedge clk_REGSEL);
      RST = 1'b1;

      // single frame
      send_frame(5'd10, 30'd35);
      idle(2);
      check_state("single");

      // back-to-back frames, zero gap
      send_frame(5'd10, 30'd35);
      send_frame(5'd22, 30'd2);
      send_frame(5'd16, 30'd100);
      idle(2);
      check_state("b2b");

      // out-of-range address
      send_frame(5'd23, 30'd7);
      idle(2);
      check_state("addr_err");

      // short address phase, then a good frame
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b1);
      drive(1'b0, 1'b1);
      sb.push_back('{kind: 3'b100, a: '0, d: '0});
      idle(2);
      send_frame(5'd5, 30'd1);
      idle(2);
      check_state("short_addr");

      // early REGSEL rise after data bit 12; that edge begins frame 3/9
      for (int i = 4; i >= 0; i--) drive(1'b1, 5'(10) >> i);
      for (int j = 0; j < 13; j++) drive(1'b0, 1'b1);
      check("mid_busy", {31'd0, busy}, 32'd1);
      sb.push_back('{kind: 3'b100, a: '0, d: '0});
      send_frame(5'd3, 30'd9);
      idle(2);
      check_state("early_rise");

      // full-width data and max valid address
      send_frame(5'd22, 30'h3FFF_FFFF);
      send_frame(5'd0, 30'h2AAA_AAA5);
      idle(2);
      check_state("extremes");

      // GRST mid-data
      for (int i = 4; i >= 0; i--) drive(1'b1, 5'(7) >> i);
      for (int j = 0; j < 8; j++) drive(1'b0, 1'b1);
      @(negedge clk_REGSEL);
      GRST = 1'b1;
      @(negedge clk_REGSEL);
      GRST = 1'b0;
      clear_model();
      check_state("grst");
      send_frame(5'd4, 30'd123);
      idle(2);
      check_state("after_grst");

      // asynchronous RST mid-frame
      for (int i = 4; i >= 0; i--) drive(1'b1, 5'(9) >> i);
      for (int j = 0; j < 5; j++) drive(1'b0, 1'b0);
      #2;
      RST = 1'b0;
      #1;
      clear_model();
      check("rst_async_busy", {31'd0, busy}, 32'd0);
      check("rst_async_wr_addr", {27'd0, wr_addr}, 32'd0);
      idle(2);
      check_state("rst_mid");
      @(negedge clk_REGSEL);
      RST = 1'b1;
      send_frame(5'd12, 30'd4242);
      idle(2);
      check_state("after_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/spi_frame_receiver.md
# spi_frame_receiver

Chip-side receiver for the serial configuration link driven by the FPGA-side frame generator. Samples SIN against REGSEL framing and assembles each frame: 5-bit slave address sent while REGSEL=1, then a 30-bit data word sent while REGSEL=0. Commits each completed word into a 23-entry slave register bank and emits a one-cycle write strobe. GRST clears the bank and holds the receiver idle.

## Interface
Parameters:
- ADDR_W, 5, slave address width
- DATA_W, 30, data word width
- NUM_SLAVES, 23, number of register bank entries (valid addresses 0..NUM_SLAVES-1)

Ports:
- clk_REGSEL  input  1  serial bit clock; all state updates on rising edge
- RST  input  1  reset, asynchronous, active-low
- GRST  input  1  chip reset, synchronous, active-high; clears bank, forces IDLE
- SIN  input  1  serial data, sampled on rising edge of clk_REGSEL
- REGSEL  input  1  frame phase: 1 = address bits, 0 = data bits; sampled with SIN
- rd_addr  input  ADDR_W  bank read address
- rd_data  output  DATA_W  combinational bank read; 0 for rd_addr >= NUM_SLAVES
- wr_stb  output  1  one-cycle pulse on frame commit
- wr_addr  output  ADDR_W  address of last committed frame
- wr_data  output  DATA_W  data of last committed frame
- frame_err  output  1  one-cycle pulse on malformed frame
- addr_err  output  1  one-cycle pulse on complete frame with address >= NUM_SLAVES
- busy  output  1  1 in ADDR or DATA state

## Operation
- States: IDLE, ADDR, DATA, WAIT.
- IDLE: REGSEL=1 -> load SIN into addr shift reg, acnt=1, go ADDR. Otherwise stay.
- ADDR, REGSEL=1: addr = {addr[ADDR_W-2:0], SIN} (MSB-first); acnt saturates at ADDR_W. More than ADDR_W bits: last ADDR_W bits retained, no error.
- ADDR, REGSEL=0: if acnt < ADDR_W -> frame_err, go WAIT (sampled SIN discarded). Else data[0]=SIN, dcnt=1, go DATA.
- DATA, REGSEL=0: data[dcnt]=SIN (LSB-first), dcnt+1. The sample with dcnt=DATA_W-1 completes the frame:
  - addr < NUM_SLAVES: bank[addr]=full word; wr_stb=1; wr_addr/wr_data update.
  - else: addr_err=1; no bank write; wr_addr/wr_data unchanged.
  - go WAIT.
- DATA, REGSEL=1 (early rise): frame_err=1; abort, no write; treat as IDLE->ADDR on the same edge (SIN becomes new address bit, acnt=1).
- WAIT: SIN ignored while REGSEL=0; REGSEL=1 -> same as IDLE start (new frame).
- Bank write and error flags are mutually exclusive per edge.
- GRST=1 on a rising edge: state=IDLE, all bank entries=0, counters=0, wr_stb/frame_err/addr_err=0; wr_addr/wr_data=0. Overrides any in-flight commit on the same edge.
- RST=0 (any time, mid-frame included): same values as GRST, applied asynchronously; held until RST=1.

## Timing
- Reset values: wr_stb=0, wr_addr=0, wr_data=0, frame_err=0, addr_err=0, busy=0, rd_data=0 for all addresses.
- Frame length: ADDR_W + DATA_W = 35 rising edges minimum; REGSEL must fall at the edge after the last address bit.
- Commit latency: wr_stb, wr_addr, wr_data, addr_err valid after the rising edge sampling data bit DATA_W-1; pulses last exactly one cycle.
- rd_data reflects the new value from the same edge that raises wr_stb.
- frame_err asserted after the offending edge, one cycle.
- Back-to-back frames: REGSEL may rise on the edge right after the last data bit (WAIT->ADDR with no gap).
- busy=1 from the edge entering ADDR through the commit edge; 0 in IDLE/WAIT.

## Test plan
- RST pulse, then frame addr=10 data=35 -> one wr_stb, wr_addr=10, wr_data=35, rd_data@10=35, all other entries 0.
- Three back-to-back frames (10/35, 22/2, 16/100) with zero gap -> three wr_stb pulses in order; bank[10]=35, bank[22]=2, bank[16]=100.
- Frame addr=23 data=7 -> addr_err pulse, no wr_stb, bank unchanged, wr_addr keeps prior value.
- REGSEL high for 3 bits then low -> frame_err pulse, no write; following valid frame 5/1 commits normally.
- REGSEL rises after data bit 12 of frame 10/35, then a full frame 3/9 follows -> frame_err once, bank[10] unchanged, bank[3]=9.
- GRST=1 for one edge mid-data, and separately RST low mid-frame -> bank all 0, outputs at reset values, next frame commits correctly.
